trigger_sequencer: RTL and testbench
====================================

// Module: trigger_sequencer
// PURPOSE
//  Multi-channel successor to the single-channel PS trigger FSM. A shared frame counter
//  marks serial TX frame boundaries. Each channel takes a trigger request and waits for
//  the next boundary, then a per-channel number of delay frames. It then asserts its
//  trigger output for HOLD frames. Sits between the trigger-input front end and the PS
//  serial TX path; is_trigger selects trigger vs idle frame payload.
// PARAMETERS
//  FRAME_LEN  10  bit-ticks per TX frame (>=2); tx_counter wraps FRAME_LEN-1 -> 0
//  NUM_CH     4   independent trigger channels (1..16)
//  DELAY_W    8   width of per-channel delay (frames)
//  HOLD_W     4   width of hold length (frames)
// PORTS
//  clk           in   1                 system clock
//  reset         in   1                 synchronous, active-high reset
//  bit_tick      in   1                 advance enable for frame counter (baud tick)
//  trigger_pulse in   NUM_CH            per-channel trigger request
//  ch_enable     in   NUM_CH            per-channel enable
//  delay_frames  in   NUM_CH*DELAY_W    per-channel delay; ch i at [i*DELAY_W +: DELAY_W]
//  hold_frames   in   HOLD_W            frames is_trigger stays high; 0 treated as 1
//  overrun_clr   in   NUM_CH            clear sticky overrun flag
//  is_trigger    out  NUM_CH            channel in ACTIVE state (Moore, registered)
//  tx_counter    out  $clog2(FRAME_LEN) current bit position in frame
//  frame_end     out  1                 bit_tick && tx_counter==FRAME_LEN-1 (comb.)
//  busy          out  1                 OR of all channels not IDLE
//  overrun       out  NUM_CH            sticky: trigger arrived while channel busy
// BEHAVIOUR
//  Reset (sync, highest priority): tx_counter=0, all channels IDLE, is_trigger=0,
//   overrun=0, busy=0, internal counters=0.
//  Counter: +1 on bit_tick; FRAME_LEN-1 -> 0 on bit_tick; holds otherwise.
//  Channel FSM (state per channel):
//   IDLE  : trig&en -> ALIGN next cycle; latch delay_frames[i], hold_frames (0->1).
//   ALIGN : frame_end -> DELAY if latched delay!=0 (dcnt=delay), else ACTIVE.
//   DELAY : frame_end -> dcnt-1; frame_end with dcnt==1 -> ACTIVE (hcnt=hold).
//   ACTIVE: is_trigger=1; frame_end -> hcnt-1; frame_end with hcnt==1 -> IDLE.
//  Latency: trigger at cycle N -> ALIGN at N+1. Trigger coincident with frame_end in
//   IDLE does not use that boundary; it waits for the next one.
//  ACTIVE spans exactly hold whole frames, boundary to boundary.
//  Busy trigger: trig&en while not IDLE is ignored and sets overrun[i] next cycle.
//   Set wins over simultaneous overrun_clr.
//  ch_enable low: new triggers ignored. Deassert while not IDLE -> IDLE next cycle,
//   is_trigger drops, no overrun set.
//  delay_frames/hold_frames changes after latch do not affect an in-flight sequence.
//  Channels are fully independent; all may be ACTIVE in the same frame.
// CONFIGURATION
//  TRIG_SYNC_EN defined: each trigger_pulse bit passes a 2-flop synchroniser, then a
//   rising-edge detector. Acceptance is 3 cycles after the input edge; a held-high
//   input is one request.
//  Undefined: trigger_pulse is a synchronous, per-cycle-sampled request. A level held
//   high re-triggers on return to IDLE, or flags overrun while busy.
// STRUCTURE
//  trigger_pkg: channel state enum (IDLE, ALIGN, DELAY, ACTIVE), one-hot encodings,
//   FRAME_LEN default constant.
//  Sub-module trigger_channel: one channel FSM plus dcnt/hcnt/overrun. Instantiated
//   NUM_CH times via generate. Frame counter, sync/edge logic and busy OR stay in top.
// TESTING
//  1 ch0 pulse at tx_counter=3, delay=0, hold=1, bit_tick=1 -> is_trigger[0] high from
//    first cycle after counter wraps 9->0, for exactly 10 cycles.
//  2 ch1 delay=2, hold=3 -> is_trigger[1] rises 2 frame_ends after ALIGN exit, holds
//    30 ticks.
//  3 ch0 second pulse while ACTIVE -> overrun[0]=1 next cycle, sequence unchanged.
//    overrun_clr with new pulse same cycle -> overrun stays 1.
//  4 pulse coincident with frame_end -> trigger starts at following boundary, not this.
//  5 ch_enable[2]=0 mid-DELAY -> IDLE next cycle, is_trigger[2] never asserts.
//    reset mid-ACTIVE -> all outputs 0 next cycle.
//  6 bit_tick every 4th cycle, all 4 chs pulsed together -> all is_trigger rise on the
//    same cycle. With TRIG_SYNC_EN, a 20-cycle input pulse yields exactly one request.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared types and constants for the multi-channel trigger sequencer.
package trigger_pkg;

  localparam int FRAME_LEN_DEFAULT = 10;

  // One-hot state encodings, so each state decodes from a single flop.
  localparam logic [3:0] ST_IDLE_OH   = 4'b0001;
  localparam logic [3:0] ST_ALIGN_OH  = 4'b0010;
  localparam logic [3:0] ST_DELAY_OH  = 4'b0100;
  localparam logic [3:0] ST_ACTIVE_OH = 4'b1000;

  typedef enum logic [3:0] {
    IDLE   = ST_IDLE_OH,
    ALIGN  = ST_ALIGN_OH,
    DELAY  = ST_DELAY_OH,
    ACTIVE = ST_ACTIVE_OH
  } ch_state_t;

endpackage

// File: rtl/trigger_channel.sv
// One trigger channel: waits for a frame boundary, counts delay frames, then
// holds is_trigger for a latched number of frames. Tracks a sticky overrun flag.
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int DELAY_W = 8,
  parameter int HOLD_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig,
  input  logic               en,
  input  logic [DELAY_W-1:0] delay,
  input  logic [HOLD_W-1:0]  hold,
  input  logic               frame_end,
  input  logic               overrun_clr,
  output logic               is_trigger,
  output logic               busy,
  output logic               overrun
);

  ch_state_t          state;
  logic [DELAY_W-1:0] delay_lat;
  logic [HOLD_W-1:0]  hold_lat;
  logic [DELAY_W-1:0] dcnt;
  logic [HOLD_W-1:0]  hcnt;

  assign busy = (state != IDLE);

  // Settings are latched on acceptance so later input changes cannot disturb
  // a sequence already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_trigger <= 1'b0;
      overrun    <= 1'b0;
      delay_lat  <= '0;
      hold_lat   <= '0;
      dcnt       <= '0;
      hcnt       <= '0;
    end else begin
      if (trig && en && state != IDLE)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      if (!en) begin
        state      <= IDLE;
        is_trigger <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              state     <= ALIGN;
              delay_lat <= delay;
              hold_lat  <= (hold == '0) ? HOLD_W'(1) : hold;
            end
          end
          ALIGN: begin
            if (frame_end) begin
              if (delay_lat != '0) begin
                state <= DELAY;
                dcnt  <= delay_lat;
              end else begin
                state      <= ACTIVE;
                is_trigger <= 1'b1;
                hcnt       <= hold_lat;
              end
            end
          end
          DELAY: begin
            if (frame_end) begin
              if (dcnt == DELAY_W'(1)) begin
                state      <= ACTIVE;
                is_trigger <= 1'b1;
                hcnt       <= hold_lat;
              end else begin
                dcnt <= dcnt - DELAY_W'(1);
              end
            end
          end
          ACTIVE: begin
            if (frame_end) begin
              if (hcnt == HOLD_W'(1)) begin
                state      <= IDLE;
                is_trigger <= 1'b0;
              end else begin
                hcnt <= hcnt - HOLD_W'(1);
              end
            end
          end
          default: begin
            state      <= IDLE;
            is_trigger <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-channel trigger sequencer aligned to serial TX frame boundaries.
// Optional macro TRIG_SYNC_EN: synchronise and edge-detect each trigger_pulse bit.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter  int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter  int NUM_CH    = 4,
  parameter  int DELAY_W   = 8,
  parameter  int HOLD_W    = 4,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bit_tick,
  input  logic [NUM_CH-1:0]         trigger_pulse,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH*DELAY_W-1:0] delay_frames,
  input  logic [HOLD_W-1:0]         hold_frames,
  input  logic [NUM_CH-1:0]         overrun_clr,
  output logic [NUM_CH-1:0]         is_trigger,
  output logic [CNT_W-1:0]          tx_counter,
  output logic                      frame_end,
  output logic                      busy,
  output logic [NUM_CH-1:0]         overrun
);

  logic [NUM_CH-1:0] trig_req;
  logic [NUM_CH-1:0] ch_busy;

  assign frame_end = bit_tick && (tx_counter == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset)
      tx_counter <= '0;
    else if (bit_tick)
      tx_counter <= (tx_counter == CNT_W'(FRAME_LEN - 1)) ? '0 : tx_counter + CNT_W'(1);
  end

`ifdef TRIG_SYNC_EN
  logic [NUM_CH-1:0] sync1, sync2, sync3;

  // Asynchronous inputs: two flops for metastability, a third for the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= trigger_pulse;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign trig_req = sync2 & ~sync3;
`else
  assign trig_req = trigger_pulse;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_channel #(
      .DELAY_W(DELAY_W),
      .HOLD_W (HOLD_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .trig       (trig_req[i]),
      .en         (ch_enable[i]),
      .delay      (delay_frames[i*DELAY_W +: DELAY_W]),
      .hold       (hold_frames),
      .frame_end  (frame_end),
      .overrun_clr(overrun_clr[i]),
      .is_trigger (is_trigger[i]),
      .busy       (ch_busy[i]),
      .overrun    (overrun[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer (default build, TRIG_SYNC_EN undefined).
// Reference model tracks absolute frame-boundary numbers per channel.
module tb_trigger_sequencer;

  localparam int FL = 10;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_tick;
  logic [3:0]  trigger_pulse;
  logic [3:0]  ch_enable;
  logic [31:0] delay_frames;
  logic [3:0]  hold_frames;
  logic [3:0]  overrun_clr;
  logic [3:0]  is_trigger;
  logic [3:0]  tx_counter;
  logic        frame_end;
  logic        busy;
  logic [3:0]  overrun;

  int n_vec = 0;
  int n_miss = 0;
  int tick_div = 1;
  int cyc = 0;

  // Reference model state
  int   mcnt;
  int   bcount;
  bit   inflight [NCH];
  int   start_b  [NCH];
  int   end_b    [NCH];
  logic [3:0] m_ovr;

  trigger_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .bit_tick     (bit_tick),
    .trigger_pulse(trigger_pulse),
    .ch_enable    (ch_enable),
    .delay_frames (delay_frames),
    .hold_frames  (hold_frames),
    .overrun_clr  (overrun_clr),
    .is_trigger   (is_trigger),
    .tx_counter   (tx_counter),
    .frame_end    (frame_end),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A channel accepted after boundary c goes active at boundary c+1+delay and
  // idles at boundary c+1+delay+hold.
  task automatic modelStep();
    bit fe, bp;
    int cpost, h;
    if (reset) begin
      mcnt = 0;
      bcount = 0;
      m_ovr = '0;
      for (int i = 0; i < NCH; i++) inflight[i] = 0;
      return;
    end
    fe = bit_tick && (mcnt == FL - 1);
    cpost = bcount + (fe ? 1 : 0);
    h = (hold_frames == 0) ? 1 : int'(hold_frames);
    for (int i = 0; i < NCH; i++) begin
      bp = inflight[i] && (bcount < end_b[i]);
      if (trigger_pulse[i] && ch_enable[i] && bp) m_ovr[i] = 1'b1;
      else if (overrun_clr[i]) m_ovr[i] = 1'b0;
      if (!ch_enable[i]) inflight[i] = 0;
      else if (!bp && trigger_pulse[i]) begin
        inflight[i] = 1;
        start_b[i] = cpost + 1 + int'(delay_frames[i*8 +: 8]);
        end_b[i] = start_b[i] + h;
      end
    end
    bcount = cpost;
    if (bit_tick) mcnt = (mcnt == FL - 1) ? 0 : mcnt + 1;
  endtask

  task automatic checkOutput();
    logic [3:0] et, eb;
    for (int i = 0; i < NCH; i++) begin
      et[i] = inflight[i] && (bcount >= start_b[i]) && (bcount < end_b[i]);
      eb[i] = inflight[i] && (bcount < end_b[i]);
    end
    chk("is_trigger", 32'(is_trigger), 32'(et));
    chk("tx_counter", 32'(tx_counter), 32'(mcnt));
    chk("frame_end", 32'(frame_end), 32'(bit_tick && (mcnt == FL - 1)));
    chk("busy", 32'(busy), 32'(|eb));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      if (tick_div == 0) bit_tick = ($urandom_range(0, 2) != 0);
      else bit_tick = ((cyc % tick_div) == 0);
      cyc++;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic waitCounter(input int value);
    for (int g = 0; g < 3 * FL && int'(tx_counter) != value; g++) applyStimulus(1);
  endtask

  int hi, first_cnt, guard;

  initial begin
    reset = 1'b1;
    trigger_pulse = '0;
    ch_enable = '1;
    delay_frames = '0;
    hold_frames = 4'd1;
    overrun_clr = '0;
    bit_tick = 1'b1;
    applyStimulus(3);
    reset = 1'b0;
    applyStimulus(2);

    // 1: ch0, delay 0, hold 1, pulse at tx_counter 3
    waitCounter(3);
    trigger_pulse = 4'b0001;
    applyStimulus(1);
    trigger_pulse = '0;
    hi = 0; first_cnt = -1;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1);
      if (is_trigger[0]) begin
        if (first_cnt < 0) first_cnt = int'(tx_counter);
        hi++;
      end
    end
    chk("t1_first_cnt", 32'(first_cnt), 32'd0);
    chk("t1_len", 32'(hi), 32'd10);

    // 2: ch1, delay 2, hold 3
    delay_frames[15:8] = 8'd2;
    hold_frames = 4'd3;
    waitCounter(3);
    trigger_pulse = 4'b0010;
    applyStimulus(1);
    trigger_pulse = '0;
    delay_frames[15:8] = 8'd7;
    hold_frames = 4'd1;
    hi = 0;
    for (int k = 0; k < 70; k++) begin
      applyStimulus(1);
      if (is_trigger[1]) hi++;
    end
    chk("t2_len", 32'(hi), 32'd30);
    delay_frames = '0;

    // 3: overrun on ch0 while active; set wins over clear
    hold_frames = 4'd2;
    trigger_pulse = 4'b0001;
    applyStimulus(1);
    trigger_pulse = '0;
    for (guard = 0; guard < 40 && !is_trigger[0]; guard++) applyStimulus(1);
    trigger_pulse = 4'b0001;
    applyStimulus(1);
    chk("t3_overrun_set", 32'(overrun[0]), 32'd1);
    overrun_clr = 4'b0001;
    applyStimulus(1);
    chk("t3_set_beats_clr", 32'(overrun[0]), 32'd1);
    trigger_pulse = '0;
    applyStimulus(1);
    chk("t3_clr", 32'(overrun[0]), 32'd0);
    overrun_clr = '0;
    applyStimulus(40);

    // 4: pulse coincident with frame_end waits for the next boundary
    hold_frames = 4'd1;
    waitCounter(FL - 1);
    trigger_pulse = 4'b1000;
    applyStimulus(1);
    trigger_pulse = '0;
    hi = 0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1);
      if (is_trigger[3]) hi++;
    end
    chk("t4_not_this_boundary", 32'(hi), 32'd0);
    applyStimulus(1);
    chk("t4_next_boundary", 32'(is_trigger[3]), 32'd1);
    applyStimulus(20);

    // 5: disable ch2 mid-delay, then reset mid-active
    delay_frames[23:16] = 8'd3;
    trigger_pulse = 4'b0100;
    applyStimulus(1);
    trigger_pulse = '0;
    applyStimulus(15);
    ch_enable[2] = 1'b0;
    applyStimulus(1);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1);
      if (is_trigger[2]) hi++;
    end
    chk("t5_never_active", 32'(hi), 32'd0);
    ch_enable = '1;
    delay_frames = '0;
    hold_frames = 4'd2;
    trigger_pulse = 4'b0001;
    applyStimulus(1);
    trigger_pulse = '0;
    for (guard = 0; guard < 40 && !is_trigger[0]; guard++) applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    chk("t5_reset_outputs", 32'({is_trigger, busy, overrun}), 32'd0);
    applyStimulus(2);

    // 6: slow bit_tick, all channels pulsed together
    tick_div = 4;
    delay_frames = 32'h01010101;
    trigger_pulse = 4'hF;
    applyStimulus(1);
    trigger_pulse = '0;
    for (guard = 0; guard < 300 && is_trigger == 4'h0; guard++) applyStimulus(1);
    chk("t6_all_rise", 32'(is_trigger), 32'hF);
    applyStimulus(100);

    // Random phase
    tick_div = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        trigger_pulse[i] = ($urandom_range(0, 15) == 0);
        overrun_clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 63) == 0) ch_enable[i] = ~ch_enable[i];
        delay_frames[i*8 +: 8] = 8'($urandom_range(0, 3));
      end
      hold_frames = 4'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) == 0);
      applyStimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
